// File: rtl/srv_icache_pkg.sv
// Shared types and helpers for the srv_icache_sa set-associative instruction cache:
// FSM state encoding, address-split widths and tree pseudo-LRU maths.
package srv_icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_REFILL = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic int offs_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int nsets);
    return $clog2(nsets);
  endfunction

  function automatic int tag_w(input int line_words, input int nsets);
    return 32 - offs_w(line_words) - idx_w(nsets);
  endfunction

  function automatic int way_w(input int nways);
    return (nways > 1) ? $clog2(nways) : 1;
  endfunction

  // Tree bits live in heap order at tree[1..7]; a 0 bit means the victim is in the left subtree.
  function automatic logic [7:0] plru_touch(input logic [7:0] tree, input int levels,
                                            input logic [2:0] way);
    logic [7:0] t;
    logic [3:0] node;
    logic [3:0] parent;
    t    = tree;
    node = 4'(1 << levels) + {1'b0, way};
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        parent            = node >> 1;
        t[parent[2:0]]    = ~node[0];
        node              = parent;
      end
    end
    return t;
  endfunction

  function automatic logic [2:0] plru_victim(input logic [7:0] tree, input int levels);
    logic [3:0] node;
    node = 4'd1;
    for (int l = 0; l < 3; l++) begin
      if (l < levels) node = {node[2:0], tree[node[2:0]]};
    end
    return 3'(node - 4'(1 << levels));
  endfunction

endpackage

// File: rtl/srv_icache_plru.sv
// One set's tree pseudo-LRU state: NWAYS-1 bits, updated toward MRU on touch.
module srv_icache_plru
  import srv_icache_pkg::*;
#(
  parameter  int NWAYS = 2,
  localparam int WAY_W = way_w(NWAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch_en,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim_way
);

  localparam int LEVELS = $clog2(NWAYS);

  logic [7:0] tree_q;

  always_ff @(posedge clk) begin
    if (!rst_n) tree_q <= '0;
    else if (touch_en) tree_q <= plru_touch(tree_q, LEVELS, 3'(touch_way));
  end

  assign victim_way = WAY_W'(plru_victim(tree_q, LEVELS));

endmodule

// File: rtl/srv_icache_sa.sv
// Set-associative instruction cache for schoolRISCV with single-request refill FSM and fence.i flush.
// Define SRV_ICACHE_PERF_EN to add the hit_cnt_o / miss_cnt_o performance counters.
module srv_icache_sa
  import srv_icache_pkg::*;
#(
  parameter int NWAYS      = 2,
  parameter int NSETS      = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     imem_req_i,
  input  logic [31:0]              imAddr,
  input  logic                     flush_i,
  output logic [31:0]              imData,
  output logic                     im_drdy,
  output logic                     busy_o,
  output logic [31:0]              ext_addr_o,
  output logic                     ext_req_o,
  input  logic                     ext_rsp_i,
  input  logic [32*LINE_WORDS-1:0] ext_data_i
`ifdef SRV_ICACHE_PERF_EN
  ,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o
`endif
);

  localparam int OFFS   = offs_w(LINE_WORDS);
  localparam int IDX    = idx_w(NSETS);
  localparam int TAG    = tag_w(LINE_WORDS, NSETS);
  localparam int IDX_B  = (IDX > 0) ? IDX : 1;
  localparam int WAY_W  = way_w(NWAYS);
  localparam int LINE_W = 32 * LINE_WORDS;

  state_t            state_q;
  logic [31:0]       addr_q;
  logic              flush_pend_q;
  logic [LINE_W-1:0] data_q  [NSETS][NWAYS];
  logic [TAG-1:0]    tag_q   [NSETS][NWAYS];
  logic [NWAYS-1:0]  valid_q [NSETS];

  logic [OFFS-1:0]   off;
  logic [IDX_B-1:0]  idx;
  logic [TAG-1:0]    tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  plru_vic [NSETS];
  logic              touch_en;
  logic [WAY_W-1:0]  touch_way;
  logic              refill_done;
  logic              to_idle;
  logic              clear_all;

  assign off = addr_q[OFFS-1:0];
  assign idx = IDX_B'((addr_q >> OFFS) & 32'(NSETS - 1));
  assign tag = addr_q[31 -: TAG];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Fill empty ways first so PLRU only arbitrates once the set is full.
  assign victim      = inv_found ? inv_way : plru_vic[idx];
  assign refill_done = (state_q == S_REFILL) && ext_rsp_i;
  assign touch_en    = ((state_q == S_LOOKUP) && hit) || refill_done;
  assign touch_way   = (state_q == S_LOOKUP) ? hit_way : victim;
  assign to_idle     = ((state_q == S_LOOKUP) && hit) || (state_q == S_RESP);
  assign clear_all   = ((state_q == S_IDLE) && flush_i) || (to_idle && (flush_pend_q || flush_i));
  assign busy_o      = (state_q != S_IDLE) || flush_pend_q;

  for (genvar s = 0; s < NSETS; s++) begin : g_set
    srv_icache_plru #(.NWAYS(NWAYS)) u_plru (
      .clk        (clk),
      .rst_n      (rst_n),
      .touch_en   (touch_en && (idx == IDX_B'(s))),
      .touch_way  (touch_way),
      .victim_way (plru_vic[s])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      imData       <= '0;
      im_drdy      <= 1'b0;
      ext_req_o    <= 1'b0;
      ext_addr_o   <= '0;
      for (int s = 0; s < NSETS; s++) valid_q[s] <= '0;
    end else begin
      im_drdy <= 1'b0;
      if ((state_q != S_IDLE) && flush_i) flush_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          // A simultaneous flush wins; the request is dropped and must be retried.
          if (imem_req_i && !flush_i) begin
            addr_q  <= imAddr;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            imData  <= data_q[idx][hit_way][{off, 5'd0} +: 32];
            im_drdy <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            ext_req_o  <= 1'b1;
            ext_addr_o <= {addr_q[31:OFFS], {OFFS{1'b0}}};
            state_q    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (ext_rsp_i) begin
            ext_req_o <= 1'b0;
            imData    <= ext_data_i[{off, 5'd0} +: 32];
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          im_drdy <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (to_idle) flush_pend_q <= 1'b0;
      if (clear_all) begin
        for (int s = 0; s < NSETS; s++) valid_q[s] <= '0;
      end else if (refill_done) begin
        valid_q[idx][victim] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && refill_done) begin
      data_q[idx][victim] <= ext_data_i;
      tag_q[idx][victim]  <= tag;
    end
  end

`ifdef SRV_ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
      else     miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_req_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(imem_req_i && busy_o));
`endif

endmodule

// File: tb/tb_srv_icache_sa.sv
// Directed bench for srv_icache_sa (2 ways, 4 sets, 4-word lines) with an expected-response queue.
module tb_srv_icache_sa;

  localparam int NWAYS      = 2;
  localparam int NSETS      = 4;
  localparam int LINE_WORDS = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req_i;
  logic [31:0]  imAddr;
  logic         flush_i;
  logic [31:0]  imData;
  logic         im_drdy;
  logic         busy_o;
  logic [31:0]  ext_addr_o;
  logic         ext_req_o;
  logic         ext_rsp_i;
  logic [127:0] ext_data_i;
`ifdef SRV_ICACHE_PERF_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  int checks     = 0;
  int errors     = 0;
  int tally_hit  = 0;
  int tally_miss = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  srv_icache_sa #(.NWAYS(NWAYS), .NSETS(NSETS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req_i (imem_req_i),
    .imAddr     (imAddr),
    .flush_i    (flush_i),
    .imData     (imData),
    .im_drdy    (im_drdy),
    .busy_o     (busy_o),
    .ext_addr_o (ext_addr_o),
    .ext_req_o  (ext_req_o),
    .ext_rsp_i  (ext_rsp_i),
    .ext_data_i (ext_data_i)
`ifdef SRV_ICACHE_PERF_EN
    ,
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
`endif
  );

  // Backing memory contents: every word is distinct across lines.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h90 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every im_drdy pops one expected instruction
  always @(negedge clk) begin
    if (rst_n === 1'b1 && im_drdy === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_drdy", {31'b0, im_drdy}, 32'd0);
      else chk("sb_imdata", imData, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n      = 1'b0;
    imem_req_i = 1'b0;
    imAddr     = '0;
    flush_i    = 1'b0;
    ext_rsp_i  = 1'b0;
    ext_data_i = '0;
    repeat (3) @(negedge clk);
    rst_n      = 1'b1;
    tally_hit  = 0;
    tally_miss = 0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input bit exp_hit, input bit flush_mid);
    logic [127:0] line;
    logic [31:0]  base;
    @(negedge clk);
    imem_req_i = 1'b1;
    imAddr     = a;
    exp_q.push_back(mem_word(a));
    if (exp_hit) tally_hit++;
    else tally_miss++;
    @(negedge clk);
    imem_req_i = 1'b0;
    imAddr     = $urandom;
    chk("lookup_busy", {31'b0, busy_o}, 32'd1);
    if (exp_hit) chk("hit_no_ext_n1", {31'b0, ext_req_o}, 32'd0);
    @(negedge clk);
    chk("ext_req_n2", {31'b0, ext_req_o}, {31'b0, !exp_hit});
    if (exp_hit) begin
      chk("hit_drdy_n2", {31'b0, im_drdy}, 32'd1);
    end else begin
      base = {a[31:2], 2'b00};
      chk("ext_addr", ext_addr_o, base);
      chk("refill_no_drdy", {31'b0, im_drdy}, 32'd0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("ext_req_hold", {31'b0, ext_req_o}, 32'd1);
      end
      if (flush_mid) begin
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_busy", {31'b0, busy_o}, 32'd1);
        chk("flush_ext_req", {31'b0, ext_req_o}, 32'd1);
      end
      for (int k = 0; k < LINE_WORDS; k++) line[32*k +: 32] = mem_word(base + 32'(k));
      ext_rsp_i  = 1'b1;
      ext_data_i = line;
      @(negedge clk);
      ext_rsp_i  = 1'b0;
      ext_data_i = {4{$urandom}};
      chk("resp_no_drdy", {31'b0, im_drdy}, 32'd0);
      chk("resp_busy", {31'b0, busy_o}, 32'd1);
      chk("ext_req_drop", {31'b0, ext_req_o}, 32'd0);
      @(negedge clk);
      chk("miss_drdy_m2", {31'b0, im_drdy}, 32'd1);
      chk("idle_busy", {31'b0, busy_o}, 32'd0);
    end
  endtask

  task automatic check_perf();
`ifdef SRV_ICACHE_PERF_EN
    chk("hit_cnt", hit_cnt_o, 32'(tally_hit));
    chk("miss_cnt", miss_cnt_o, 32'(tally_miss));
`endif
  endtask

  initial begin
    logic [31:0] base;
    do_reset();
    chk("rst_imdata", imData, 32'd0);
    chk("rst_drdy", {31'b0, im_drdy}, 32'd0);
    chk("rst_ext_req", {31'b0, ext_req_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_ext_addr", ext_addr_o, 32'd0);
    check_perf();

    // cold miss, hit, then eviction within set 0
    fetch(32'h10, 1'b0, 1'b0);
    fetch(32'h13, 1'b1, 1'b0);
    fetch(32'h00, 1'b0, 1'b0);
    fetch(32'h10, 1'b1, 1'b0);
    fetch(32'h00, 1'b1, 1'b0);
    fetch(32'h20, 1'b0, 1'b0);
    fetch(32'h00, 1'b1, 1'b0);
    fetch(32'h10, 1'b0, 1'b0);
    fetch(32'h02, 1'b1, 1'b0);

    // other sets, random offsets
    for (int s = 1; s < NSETS; s++) begin
      base = 32'h100 + 32'(4 * s);
      fetch(base + 32'($urandom_range(0, 3)), 1'b0, 1'b0);
      fetch(base + 32'($urandom_range(0, 3)), 1'b1, 1'b0);
    end
    check_perf();

    // flush during refill: response completes, cache then empty
    fetch(32'h40, 1'b0, 1'b1);
    fetch(32'h40, 1'b0, 1'b0);
    fetch(32'h105, 1'b0, 1'b0);
    fetch(32'h41, 1'b1, 1'b0);

    // flush in idle
    pulse_flush();
    fetch(32'h40, 1'b0, 1'b0);

    // flush together with a request: request is dropped
    @(negedge clk);
    flush_i    = 1'b1;
    imem_req_i = 1'b1;
    imAddr     = 32'h40;
    @(negedge clk);
    flush_i    = 1'b0;
    imem_req_i = 1'b0;
    @(negedge clk);
    chk("drop_no_ext_req", {31'b0, ext_req_o}, 32'd0);
    chk("drop_no_drdy", {31'b0, im_drdy}, 32'd0);
    chk("drop_busy", {31'b0, busy_o}, 32'd0);
    fetch(32'h40, 1'b0, 1'b0);
    check_perf();

    // reset in the middle of a refill
    @(negedge clk);
    imem_req_i = 1'b1;
    imAddr     = 32'h50;
    @(negedge clk);
    imem_req_i = 1'b0;
    @(negedge clk);
    chk("mid_ext_req", {31'b0, ext_req_o}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ext_req", {31'b0, ext_req_o}, 32'd0);
    chk("rst_mid_drdy", {31'b0, im_drdy}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_mid_imdata", imData, 32'd0);
    rst_n      = 1'b1;
    tally_hit  = 0;
    tally_miss = 0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_drdy", {31'b0, im_drdy}, 32'd0);
    end
    fetch(32'h50, 1'b0, 1'b0);
    fetch(32'h51, 1'b1, 1'b0);
    check_perf();

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
